fetch_controller: RTL and testbench
===================================

Name: fetch_controller

Overview:
- Instruction-fetch sequencer that owns the program counter and drives the address of the combinational instruction memory.
- Captures each returned 32-bit word, together with its PC, into a small prefetch FIFO.
- Presents FIFO entries to decode through a valid/ready handshake.
- Handles control-flow redirects with a flush, and stops fetching at the memory limit.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- PC_STEP, 4, byte increment per fetch. Memory is byte-addressed, one word every 4 addresses.
- FIFO_DEPTH, 2, prefetch entries. Legal values: 2 or 4.
- MEM_LIMIT, 32'h0000_003C, last valid fetch address. Fetch stops when PC > MEM_LIMIT.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  level; leaves IDLE when sampled high.
- redirect_valid  input  1  one-cycle pulse: branch/jump taken.
- redirect_pc  input  32  redirect target byte address.
- address  output  32  instruction memory address; combinational copy of the PC register.
- inst  input  32  instruction word returned combinationally by memory for address.
- inst_valid  output  1  FIFO head valid.
- inst_out  output  32  FIFO head instruction.
- inst_pc  output  32  FIFO head PC.
- inst_ready  input  1  decode accepts head this cycle.
- busy  output  1  state is FETCH.
- done  output  1  state is DONE and FIFO empty.

Behaviour:
- Reset: when rst_n is sampled low at a rising edge:
  - pc <= RESET_PC; FIFO count <= 0; read/write pointers <= 0; state <= IDLE.
  - Resulting outputs: address = RESET_PC, inst_valid = 0, inst_out = 0, inst_pc = 0, busy = 0, done = 0.
  - Reset overrides every other input, including mid-fetch or mid-redirect.
- States: IDLE, FETCH, DONE.
  - IDLE: no pushes. start=1 -> FETCH.
  - FETCH: push when allowed (see FIFO rules). If pc+PC_STEP > MEM_LIMIT on a push edge -> DONE.
  - DONE: no pushes. address holds the last pc value, which is > MEM_LIMIT.
- Push condition: state == FETCH and (count < FIFO_DEPTH or pop this cycle).
  - On push: entry <= {pc, inst}; pc <= pc + PC_STEP (32-bit wrap, no overflow flag).
- Pop condition: inst_valid && inst_ready. On pop, read pointer advances.
  - Simultaneous push and pop when full is allowed; count is unchanged.
  - Pop when empty is ignored.
- Output timing: inst_valid = (count != 0). inst_out and inst_pc come from the head entry. All outputs are registered-state-derived; no combinational path from inst_ready to inst_valid.
- Latency: start sampled at edge E -> FETCH after E -> first push at E+1 -> inst_valid high after E+1. Steady state is one instruction per cycle when inst_ready is held high.
- Redirect: highest priority below reset, in any state.
  - FIFO flushed (count <= 0, pointers <= 0); no push and no pop count that cycle.
  - pc <= {redirect_pc[31:2], 2'b00}, i.e. misaligned targets are truncated.
  - state <= FETCH, or DONE if the truncated target > MEM_LIMIT.
  - A redirect while in IDLE also starts fetching.
- start is ignored outside IDLE.
- Pointers wrap modulo FIFO_DEPTH. Count width is clog2(FIFO_DEPTH)+1.
- done is asserted only after the last fetched entry has been popped.

Test Plan:
1. Reset, then start=1 for one cycle, inst_ready=1, memory returning word[addr]. Required:
   - First accepted {inst_pc, inst_out} = {0, 32'h0000B037}; next {4, 32'hBCD00013}; next {8, 32'h0000A023}.
   - One instruction per cycle thereafter.
2. inst_ready=0 after start.
   - FIFO fills to 2 entries (pc 0, 4); address then holds 8 with no further pushes.
   - Raise inst_ready: entries pop in order 0, 4, 8 with no bubble.
3. Redirect with 2 entries queued, redirect_pc=0x22.
   - Next cycle inst_valid=0; pc=0x20.
   - Following cycle head = {0x20, 32'h06108013}.
4. Run to the end with inst_ready=1.
   - Last accepted inst_pc = 0x3C; busy drops; done=1 after that pop; address stays 0x40.
   - Then a redirect to 0x30 resumes fetching with head {0x30, 32'h00008013}.
5. Assert rst_n=0 for one cycle during FETCH with a full FIFO.
   - Next cycle: inst_valid=0, address=0, busy=0, state IDLE.
   - start is required to resume.
6. redirect_valid=1 and start=1 in the same IDLE cycle, redirect_pc=0x10.
   - Redirect wins: first head {0x10, 32'h0000A223}.

Source files
------------

// File: rtl/fetch_controller_if.sv
// Fetch-side bundle: control inputs, instruction-memory port and the decode handshake.
// The master modport belongs to the fetch controller, the slave modport to its environment.
interface fetch_controller_if;
    logic        start;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] address;
    logic [31:0] inst;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        busy;
    logic        done;

    modport master (
        input  start,
        input  redirect_valid,
        input  redirect_pc,
        input  inst,
        input  inst_ready,
        output address,
        output inst_valid,
        output inst_out,
        output inst_pc,
        output busy,
        output done
    );

    modport slave (
        output start,
        output redirect_valid,
        output redirect_pc,
        output inst,
        output inst_ready,
        input  address,
        input  inst_valid,
        input  inst_out,
        input  inst_pc,
        input  busy,
        input  done
    );
endinterface

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the PC, pushes {pc, inst} into a small prefetch FIFO
// and hands entries to decode over valid/ready, with redirect flush and a fetch limit.
module fetch_controller #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          PC_STEP    = 4,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] MEM_LIMIT  = 32'h0000_003C
) (
    input logic              clk,
    input logic              rst_n,
    fetch_controller_if.master bus
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [31:0]      STEP_C  = 32'(PC_STEP);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [31:0]       pc;
    logic [31:0]       pc_next;
    logic [31:0]       pc_plus;
    logic [31:0]       redirect_target;

    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [31:0]       fifo_inst [FIFO_DEPTH];
    logic [31:0]       fifo_pc   [FIFO_DEPTH];

    logic              fifo_empty;
    logic              fifo_full;
    logic              push;
    logic              pop;
    logic              flush;

    assign fifo_empty      = (count == '0);
    assign fifo_full       = (count == DEPTH_C);
    assign pc_plus         = pc + STEP_C;
    assign redirect_target = bus.redirect_pc & 32'hFFFF_FFFC;

    // Redirect pre-empts everything except reset: no push or pop is counted in that cycle.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        push       = 1'b0;
        pop        = 1'b0;
        flush      = 1'b0;

        if (bus.redirect_valid) begin
            flush   = 1'b1;
            pc_next = redirect_target;
            if (redirect_target > MEM_LIMIT) begin
                state_next = DONE;
            end else begin
                state_next = FETCH;
            end
        end else begin
            pop = !fifo_empty && bus.inst_ready;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state_next = FETCH;
                    end
                end
                FETCH: begin
                    push = !fifo_full || pop;
                    if (push) begin
                        pc_next = pc_plus;
                        if (pc_plus > MEM_LIMIT) begin
                            state_next = DONE;
                        end
                    end
                end
                DONE: begin
                    state_next = DONE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            pc    <= RESET_PC;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (flush) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            fifo_inst[wr_ptr] <= bus.inst;
            fifo_pc[wr_ptr]   <= pc;
        end
    end

    always_comb begin
        bus.address    = pc;
        bus.inst_valid = !fifo_empty;
        bus.inst_out   = '0;
        bus.inst_pc    = '0;
        if (!fifo_empty) begin
            bus.inst_out = fifo_inst[rd_ptr];
            bus.inst_pc  = fifo_pc[rd_ptr];
        end
        bus.busy = (state == FETCH);
        bus.done = (state == DONE) && fifo_empty;
    end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed and randomized checks of fetch_controller against a queue-based reference model
// and a combinational instruction memory held in the bench.
module tb_fetch_controller;

    localparam logic [31:0] LIMIT = 32'h0000_003C;
    localparam int          DEPTH = 2;
    localparam int M_IDLE  = 0;
    localparam int M_FETCH = 1;
    localparam int M_DONE  = 2;

    logic clk = 1'b0;
    logic rst_n;
    fetch_controller_if bus ();

    fetch_controller #(
        .RESET_PC   (32'h0000_0000),
        .PC_STEP    (4),
        .FIFO_DEPTH (DEPTH),
        .MEM_LIMIT  (LIMIT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    int          m_mode;
    logic [31:0] m_pc;
    logic [63:0] m_q[$];
    logic [63:0] acc[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a > LIMIT) return 32'h0000_0000;
        case (a[5:2])
            4'd0:    return 32'h0000_B037;
            4'd1:    return 32'hBCD0_0013;
            4'd2:    return 32'h0000_A023;
            4'd4:    return 32'h0000_A223;
            4'd8:    return 32'h0610_8013;
            4'd12:   return 32'h0000_8013;
            default: return {16'hC0DE, 12'h000, a[5:2]};
        endcase
    endfunction

    assign bus.inst = mem_word(bus.address);

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        logic        e_valid;
        logic [63:0] head;
        e_valid = (m_q.size() != 0);
        head    = e_valid ? m_q[0] : 64'h0;
        checkEq("inst_valid", {31'h0, bus.inst_valid}, {31'h0, e_valid});
        checkEq("inst_pc", bus.inst_pc, head[63:32]);
        checkEq("inst_out", bus.inst_out, head[31:0]);
        checkEq("address", bus.address, m_pc);
        checkEq("busy", {31'h0, bus.busy}, {31'h0, (m_mode == M_FETCH)});
        checkEq("done", {31'h0, bus.done}, {31'h0, (m_mode == M_DONE && m_q.size() == 0)});
    endtask

    // One clock of the reference model, expressed as queue operations on the fetch rules.
    task automatic modelStep();
        bit popped;
        bit pushed;
        if (!rst_n) begin
            m_pc   = 32'h0;
            m_mode = M_IDLE;
            m_q.delete();
        end else if (bus.redirect_valid) begin
            m_q.delete();
            m_pc   = bus.redirect_pc & ~32'h3;
            m_mode = (m_pc > LIMIT) ? M_DONE : M_FETCH;
        end else begin
            popped = (m_q.size() != 0) && bus.inst_ready;
            pushed = (m_mode == M_FETCH) && (m_q.size() < DEPTH || popped);
            if (popped) void'(m_q.pop_front());
            if (pushed) begin
                m_q.push_back({m_pc, mem_word(m_pc)});
                if (m_pc + 32'd4 > LIMIT) m_mode = M_DONE;
                m_pc = m_pc + 32'd4;
            end
            if (m_mode == M_IDLE && bus.start) m_mode = M_FETCH;
        end
    endtask

    task automatic applyStimulus(input logic r, input logic s, input logic rv,
                                 input logic [31:0] rpc, input logic rdy);
        rst_n              = r;
        bus.start          = s;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.inst_ready     = rdy;
        #1;
        if (check_en) begin
            checkOutput();
            if (r && !rv && bus.inst_valid && rdy) acc.push_back({bus.inst_pc, bus.inst_out});
        end
        modelStep();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit finished;
        m_mode = M_IDLE;
        m_pc   = 32'h0;
        @(posedge clk);
        #1;
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        check_en = 1'b1;
        checkEq("reset_address", bus.address, 32'h0);
        checkEq("reset_inst_out", bus.inst_out, 32'h0);

        // Streaming fetch with decode always ready.
        acc.delete();
        applyStimulus(1, 1, 0, 0, 1);
        for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 0, 1);
        checkEq("t1_count", acc.size(), 4);
        if (acc.size() >= 3) begin
            checkEq("t1_pc0", acc[0][63:32], 32'h0);
            checkEq("t1_inst0", acc[0][31:0], 32'h0000_B037);
            checkEq("t1_pc1", acc[1][63:32], 32'h4);
            checkEq("t1_inst1", acc[1][31:0], 32'hBCD0_0013);
            checkEq("t1_pc2", acc[2][63:32], 32'h8);
            checkEq("t1_inst2", acc[2][31:0], 32'h0000_A023);
        end

        // Back-pressure fills the FIFO, then drains with no bubble.
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0);
        checkEq("t2_address_hold", bus.address, 32'h8);
        checkEq("t2_head_pc", bus.inst_pc, 32'h0);
        acc.delete();
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 1);
        checkEq("t2_count", acc.size(), 3);
        if (acc.size() == 3) begin
            checkEq("t2_pc0", acc[0][63:32], 32'h0);
            checkEq("t2_pc1", acc[1][63:32], 32'h4);
            checkEq("t2_pc2", acc[2][63:32], 32'h8);
        end

        // Redirect with a full FIFO to a misaligned target.
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0);
        checkEq("t3_full_valid", {31'h0, bus.inst_valid}, 32'h1);
        applyStimulus(1, 0, 1, 32'h22, 0);
        checkEq("t3_flush_valid", {31'h0, bus.inst_valid}, 32'h0);
        checkEq("t3_pc", bus.address, 32'h20);
        applyStimulus(1, 0, 0, 0, 0);
        checkEq("t3_head_pc", bus.inst_pc, 32'h20);
        checkEq("t3_head_inst", bus.inst_out, 32'h0610_8013);

        // Run to the fetch limit, then resume with a redirect.
        acc.delete();
        finished = 1'b0;
        for (int i = 0; i < 40 && !finished; i++) begin
            applyStimulus(1, 0, 0, 0, 1);
            finished = (m_mode == M_DONE) && (m_q.size() == 0);
        end
        checkEq("t4_reached_end", {31'h0, finished}, 32'h1);
        if (acc.size() > 0) checkEq("t4_last_pc", acc[acc.size()-1][63:32], 32'h3C);
        else checkEq("t4_any_accepted", acc.size(), 1);
        checkEq("t4_done", {31'h0, bus.done}, 32'h1);
        checkEq("t4_busy", {31'h0, bus.busy}, 32'h0);
        checkEq("t4_address", bus.address, 32'h40);
        applyStimulus(1, 0, 0, 0, 1);
        checkEq("t4_address_stays", bus.address, 32'h40);
        applyStimulus(1, 0, 1, 32'h30, 0);
        applyStimulus(1, 0, 0, 0, 0);
        checkEq("t4_resume_pc", bus.inst_pc, 32'h30);
        checkEq("t4_resume_inst", bus.inst_out, 32'h0000_8013);

        // Reset in the middle of fetching with a full FIFO.
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 1);
        checkEq("t5_valid", {31'h0, bus.inst_valid}, 32'h0);
        checkEq("t5_address", bus.address, 32'h0);
        checkEq("t5_busy", {31'h0, bus.busy}, 32'h0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 1);
        checkEq("t5_idle_address", bus.address, 32'h0);
        checkEq("t5_idle_busy", {31'h0, bus.busy}, 32'h0);
        applyStimulus(1, 1, 0, 0, 1);
        checkEq("t5_restart_busy", {31'h0, bus.busy}, 32'h1);

        // Redirect and start together in IDLE.
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(1, 1, 1, 32'h10, 0);
        applyStimulus(1, 0, 0, 0, 0);
        checkEq("t6_head_pc", bus.inst_pc, 32'h10);
        checkEq("t6_head_inst", bus.inst_out, 32'h0000_A223);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom % 64) != 0, ($urandom % 4) == 0, ($urandom % 16) == 0,
                          $urandom_range(32'h50, 0), ($urandom % 3) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
